// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
// Kept separate so the top and any wrapper agree on chunk count and index width.
package chunked_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk configuration still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle between issue, the adder and writeback.
// master = producer/consumer side, slave = the adder.
interface chunked_serial_adder_if #(parameter int WIDTH = 32);

   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] io_a;
   logic [WIDTH-1:0] io_b;
   logic             io_cin;
   logic             io_sub;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [WIDTH-1:0] io_sum;
   logic             io_cout;
   logic             io_overflow;

   modport master (
      output io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
      input  io_in_ready, io_out_valid, io_sum, io_cout, io_overflow
   );

   modport slave (
      input  io_in_valid, io_a, io_b, io_cin, io_sub, io_out_ready,
      output io_in_ready, io_out_valid, io_sum, io_cout, io_overflow
   );

endinterface

// File: rtl/chunked_serial_adder_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells. Also exposes the carry
// into the chunk MSB so the top can form signed overflow on the last chunk.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/sub: one CHUNK-bit slice per clock through a single
// shared chunk_adder, with the inter-chunk carry held in a register.
module chunked_serial_adder
   import chunked_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic                   clock,
   input  logic                   reset,
   chunked_serial_adder_if.slave  io
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t            state, state_nx;
   logic [IDXW-1:0]   idx;
   logic [WIDTH-1:0]  op_a, op_b, sum_r;
   logic              carry, cout_r, ovf_r;
   logic              accept, step, last;

   logic [31:0]       base;
   logic [CHUNK-1:0]  ch_a, ch_b, ch_sum;
   logic              ch_cout, ch_cmsb;

   assign base = 32'(idx) * 32'(CHUNK);
   assign ch_a = op_a[base +: CHUNK];
   assign ch_b = op_b[base +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a        (ch_a),
      .b        (ch_b),
      .cin      (carry),
      .sum      (ch_sum),
      .cout     (ch_cout),
      .c_msb_in (ch_cmsb)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE: begin
            if (io.io_in_valid) begin
               accept   = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (idx == LAST_IDX) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (io.io_out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Subtraction is A + ~B + 1, so the operand is inverted once at accept time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         idx    <= '0;
         op_a   <= io.io_a;
         op_b   <= io.io_sub ? ~io.io_b : io.io_b;
         carry  <= io.io_sub ? 1'b1 : io.io_cin;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (step) begin
         sum_r[base +: CHUNK] <= ch_sum;
         carry                <= ch_cout;
         idx                  <= idx + 1'b1;
         if (last) begin
            cout_r <= ch_cout;
            ovf_r  <= ch_cout ^ ch_cmsb;
         end
      end
   end

   assign io.io_in_ready  = (state == IDLE);
   assign io.io_out_valid = (state == DONE);
   assign io.io_sum       = sum_r;
   assign io.io_cout      = cout_r;
   assign io.io_overflow  = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and random checks of chunked_serial_adder in a 32/8 and a 16/16 configuration.
module tb_chunked_serial_adder;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   chunked_serial_adder_if #(.WIDTH(32)) i32 ();
   chunked_serial_adder_if #(.WIDTH(16)) i16 ();

   chunked_serial_adder #(.WIDTH(32), .CHUNK(8))  dut32 (.clock(clock), .reset(reset), .io(i32));
   chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clock(clock), .reset(reset), .io(i16));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // {cout, ovf, sum}
   function automatic logic [33:0] model32(input logic [31:0] a, b, input logic cin, sub);
      logic [31:0] bb;
      logic [32:0] full;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      return {full[32], (a[31] == bb[31]) && (full[31] != a[31]), full[31:0]};
   endfunction

   function automatic logic [17:0] model16(input logic [15:0] a, b, input logic cin, sub);
      logic [15:0] bb;
      logic [16:0] full;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      return {full[16], (a[15] == bb[15]) && (full[15] != a[15]), full[15:0]};
   endfunction

   // Returns #1 after the accepting edge with operands scrambled, so late changes are exercised.
   task automatic start32(input logic [31:0] a, b, input logic cin, sub);
      @(negedge clock);
      i32.io_a = a; i32.io_b = b; i32.io_cin = cin; i32.io_sub = sub;
      i32.io_in_valid = 1'b1;
      @(posedge clock); #1;
      i32.io_in_valid = 1'b0;
      i32.io_a = ~a; i32.io_b = ~b; i32.io_cin = ~cin; i32.io_sub = ~sub;
   endtask

   task automatic wait32(output int lat);
      lat = 0;
      while (!i32.io_out_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic ack32();
      i32.io_out_ready = 1'b1;
      @(posedge clock); #1;
      i32.io_out_ready = 1'b0;
   endtask

   task automatic op32(input logic [31:0] a, b, input logic cin, sub, output logic [33:0] res, output int lat);
      start32(a, b, cin, sub);
      wait32(lat);
      res = {i32.io_cout, i32.io_overflow, i32.io_sum};
      ack32();
   endtask

   task automatic op16(input logic [15:0] a, b, input logic cin, sub, output logic [17:0] res, output int lat);
      @(negedge clock);
      i16.io_a = a; i16.io_b = b; i16.io_cin = cin; i16.io_sub = sub;
      i16.io_in_valid = 1'b1;
      @(posedge clock); #1;
      i16.io_in_valid = 1'b0;
      i16.io_a = ~a; i16.io_b = ~b;
      lat = 0;
      while (!i16.io_out_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      res = {i16.io_cout, i16.io_overflow, i16.io_sum};
      i16.io_out_ready = 1'b1;
      @(posedge clock); #1;
      i16.io_out_ready = 1'b0;
   endtask

   initial begin
      logic [33:0] r32;
      logic [17:0] r16;
      int          lat;
      logic [31:0] ra, rb;
      logic        rc, rs;

      i32.io_in_valid = 0; i32.io_a = 0; i32.io_b = 0; i32.io_cin = 0; i32.io_sub = 0; i32.io_out_ready = 0;
      i16.io_in_valid = 0; i16.io_a = 0; i16.io_b = 0; i16.io_cin = 0; i16.io_sub = 0; i16.io_out_ready = 0;

      // reset state
      #12;
      chk("rst32_out", {i32.io_out_valid, i32.io_cout, i32.io_overflow, i32.io_sum}, 64'h0);
      chk("rst16_out", {i16.io_out_valid, i16.io_cout, i16.io_overflow, i16.io_sum}, 64'h0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      chk("rst32_inrdy", i32.io_in_ready, 1);
      chk("rst16_inrdy", i16.io_in_ready, 1);

      // 1: full carry ripple, latency
      op32(32'hFFFF_FFFF, 32'h1, 0, 0, r32, lat);
      chk("t1_res", r32, {1'b1, 1'b0, 32'h0000_0000});
      chk("t1_lat", lat, 4);
      chk("t1_inrdy", i32.io_in_ready, 1);

      // 2: signed overflow, carry across chunk with cin
      op32(32'h7FFF_FFFF, 32'h1, 0, 0, r32, lat);
      chk("t2_ovf", r32, {1'b0, 1'b1, 32'h8000_0000});
      op32(32'h0000_00FF, 32'h1, 1, 0, r32, lat);
      chk("t2_cross", r32, {1'b0, 1'b0, 32'h0000_0101});

      // 3: subtraction, cin ignored
      op32(32'd5, 32'd7, 1, 1, r32, lat);
      chk("t3_sub_neg", r32, {1'b0, 1'b0, 32'hFFFF_FFFE});
      op32(32'h8000_0000, 32'h1, 0, 1, r32, lat);
      chk("t3_sub_ovf", r32, {1'b1, 1'b1, 32'h7FFF_FFFF});

      // 4: backpressure in DONE with a competing request
      start32(32'h1234_5678, 32'h1111_1111, 0, 0);
      wait32(lat);
      chk("t4_lat", lat, 4);
      i32.io_a = 32'hDEAD_BEEF; i32.io_b = 32'h0BAD_F00D; i32.io_in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         chk("t4_hold", {i32.io_out_valid, i32.io_in_ready, i32.io_cout, i32.io_overflow, i32.io_sum},
             {1'b1, 1'b0, 1'b0, 1'b0, 32'h2345_6789});
      end
      i32.io_in_valid = 1'b0;
      ack32();
      chk("t4_after", {i32.io_in_ready, i32.io_out_valid}, 2'b10);
      @(posedge clock); #1;
      chk("t4_idle", {i32.io_in_ready, i32.io_out_valid}, 2'b10);

      // 5: reset during BUSY, then a clean op
      start32(32'h0101_80FF, 32'h0101_8001, 0, 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("t5_abort", {i32.io_out_valid, i32.io_cout, i32.io_overflow, i32.io_sum}, 64'h0);
      @(negedge clock); reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         chk("t5_noemit", {i32.io_out_valid, i32.io_in_ready}, 2'b01);
      end
      op32(32'd3, 32'd4, 0, 0, r32, lat);
      chk("t5_fresh", r32, {1'b0, 1'b0, 32'd7});

      // 6: single-chunk config
      op16(16'hFFFF, 16'h0001, 0, 0, r16, lat);
      chk("t6_res", r16, {1'b1, 1'b0, 16'h0000});
      chk("t6_lat", lat, 1);
      op16(16'h8000, 16'h0001, 0, 1, r16, lat);
      chk("t6_sub_ovf", r16, {1'b1, 1'b1, 16'h7FFF});

      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         op32(ra, rb, rc, rs, r32, lat);
         chk("rnd32", {lat[7:0], r32}, {8'd4, model32(ra, rb, rc, rs)});
      end
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         op16(ra[15:0], rb[15:0], rc, rs, r16, lat);
         chk("rnd16", {lat[7:0], r16}, {8'd1, model16(ra[15:0], rb[15:0], rc, rs)});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
